// File: rtl/relu_maxpool2x2.sv
// Streaming ReLU + 2x2/stride-2 max-pool with a half-row line buffer.
// Optional ReLU clamp enabled by defining RELU_EN.
module relu_maxpool2x2 #(
  parameter int IMG_W  = 28,
  parameter int IMG_H  = 28,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_sof,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  output logic              frame_err
);

  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);

  logic [CW-1:0] col, ecol;
  logic [RW-1:0] row, erow;
  logic          acc, at_org, col_end, row_end, done;

  logic signed [DATA_W-1:0] v, h_reg, p, m, lb;
  logic signed [DATA_W-1:0] lbuf [IMG_W/2];

  assign in_ready = !out_valid || out_ready;
  assign acc      = in_valid && in_ready;
  assign at_org   = (row == '0) && (col == '0);

  // SOF forces the beat to the frame origin
  assign ecol    = in_sof ? '0 : col;
  assign erow    = in_sof ? '0 : row;
  assign col_end = ecol == CW'(IMG_W - 1);
  assign row_end = erow == RW'(IMG_H - 1);

`ifdef RELU_EN
  assign v = in_data[DATA_W-1] ? '0 : $signed(in_data);
`else
  assign v = $signed(in_data);
`endif

  assign lb   = lbuf[ecol[CW-1:1]];
  assign p    = (v > h_reg) ? v : h_reg;
  assign m    = (lb > p) ? lb : p;
  assign done = acc && ecol[0] && erow[0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col       <= '0;
      row       <= '0;
      h_reg     <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      if (acc) begin
        if (col_end) begin
          col <= '0;
          row <= row_end ? '0 : erow + RW'(1);
        end else begin
          col <= ecol + CW'(1);
          row <= erow;
        end
        if (!ecol[0]) h_reg <= v;
        if (in_sof && !at_org) frame_err <= 1'b1;
      end
      if (done) begin
        out_valid <= 1'b1;
        out_data  <= m;
        out_last  <= row_end && col_end;
      end else if (out_ready) begin
        out_valid <= 1'b0;
        out_last  <= 1'b0;
      end
    end
  end

  // line buffer needs no reset: every entry is written on an even row first
  always_ff @(posedge clk) begin
    if (acc && ecol[0] && !erow[0]) lbuf[ecol[CW-1:1]] <= p;
  end

endmodule

// File: tb/tb_relu_maxpool2x2.sv
// Randomized bench for relu_maxpool2x2 against a frame-level pooling model.
// Works with or without RELU_EN defined.
module tb_relu_maxpool2x2;

  logic        clk = 0;
  logic        rst;
  logic        in_valid, in_ready, in_sof;
  logic [15:0] in_data;
  logic        out_valid, out_ready, out_last, frame_err;
  logic [15:0] out_data;

  relu_maxpool2x2 dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_sof(in_sof), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_last(out_last),
    .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;
  int n_out = 0;
  int mode = 0;
  bit held = 0;

  logic signed [15:0] img [28][28];
  logic [16:0] q [$];

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic signed [15:0] f(input logic signed [15:0] x);
`ifdef RELU_EN
    return (x < 0) ? 16'sd0 : x;
`else
    return x;
`endif
  endfunction

  function automatic logic signed [15:0] mx(input logic signed [15:0] a,
                                            input logic signed [15:0] b);
    return (a > b) ? a : b;
  endfunction

  // push every window whose bottom-right beat index is below n
  task automatic build_exp(input int n);
    logic signed [15:0] m;
    for (int r = 0; r < 14; r++)
      for (int c = 0; c < 14; c++)
        if ((2*r+1)*28 + 2*c+1 < n) begin
          m = mx(mx(f(img[2*r][2*c]), f(img[2*r][2*c+1])),
                 mx(f(img[2*r+1][2*c]), f(img[2*r+1][2*c+1])));
          q.push_back({(r == 13 && c == 13), m});
        end
  endtask

  task automatic fill_rand();
    for (int r = 0; r < 28; r++)
      for (int c = 0; c < 28; c++)
        img[r][c] = 16'($urandom);
  endtask

  task automatic send(input logic [15:0] d, input logic s);
    int t = 0;
    in_valid = 1;
    in_data = d;
    in_sof = s;
    @(negedge clk);
    while (!in_ready && t < 1000) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) check("in_timeout", 0, 1);
    @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input int n, input logic sof_first);
    for (int i = 0; i < n; i++)
      send(img[i/28][i%28], sof_first && (i == 0));
  endtask

  task automatic drain(input int exp_n, input string tag);
    int t = 0;
    in_valid = 0;
    in_sof = 0;
    while (q.size() != 0 && t < 500) begin
      @(negedge clk);
      t++;
    end
    repeat (3) @(negedge clk);
    check({tag, "_left"}, q.size(), 0);
    check({tag, "_cnt"}, n_out, exp_n);
    n_out = 0;
    q.delete();
    @(posedge clk);
    #1;
  endtask

  // scoreboard: a transfer completes on the next rising edge
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      n_out++;
      if (q.size() == 0) begin
        check("extra_out", {16'b0, out_data}, 32'hdead);
      end else begin
        logic [16:0] e;
        e = q.pop_front();
        check("data", {16'b0, out_data}, {16'b0, e[15:0]});
        check("last", {31'b0, out_last}, {31'b0, e[16]});
      end
    end
  end

  // out_ready driver: 0 = always on, 1 = random, 2 = one 10-cycle stall
  initial begin
    logic [15:0] hd;
    out_ready = 1;
    forever begin
      @(posedge clk);
      #1;
      if (mode == 0) out_ready = 1;
      else if (mode == 1) out_ready = ($urandom_range(0, 3) != 0);
      else if (mode == 2 && out_valid) begin
        out_ready = 0;
        hd = out_data;
        repeat (10) begin
          @(negedge clk);
          check("stall_rdy", {31'b0, in_ready}, 0);
          check("stall_vld", {31'b0, out_valid}, 1);
          check("stall_dat", {16'b0, out_data}, {16'b0, hd});
          @(posedge clk);
          #1;
        end
        out_ready = 1;
        held = 1;
        mode = 0;
      end
    end
  end

  initial begin
    rst = 1;
    in_valid = 0;
    in_sof = 0;
    in_data = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", {31'b0, in_ready}, 1);
    check("rst_out_valid", {31'b0, out_valid}, 0);
    check("rst_out_data", {16'b0, out_data}, 0);
    check("rst_out_last", {31'b0, out_last}, 0);
    check("rst_frame_err", {31'b0, frame_err}, 0);
    @(posedge clk);
    #1;
    rst = 0;

    // ramp frame
    for (int r = 0; r < 28; r++)
      for (int c = 0; c < 28; c++)
        img[r][c] = 16'(r*28 + c);
    build_exp(784);
    send_frame(784, 1);
    drain(196, "ramp");
    check("ramp_err", {31'b0, frame_err}, 0);

    // negative window at the origin, random backpressure
    fill_rand();
    img[0][0] = -16'sd5;
    img[0][1] = -16'sd3;
    img[1][0] = -16'sd7;
    img[1][1] = -16'sd2;
    mode = 1;
    build_exp(784);
    send_frame(784, 1);
    mode = 0;
    drain(196, "neg");

    // single long stall
    fill_rand();
    mode = 2;
    build_exp(784);
    send_frame(784, 1);
    drain(196, "stall");
    check("stall_done", {31'b0, held}, 1);

    // two back-to-back frames
    fill_rand();
    build_exp(784);
    send_frame(784, 1);
    build_exp(784);
    send_frame(784, 1);
    drain(392, "b2b");
    check("b2b_err", {31'b0, frame_err}, 0);

    // SOF at (3,5) restarts the frame
    fill_rand();
    build_exp(89);
    send_frame(89, 1);
    drain(16, "part");
    fill_rand();
    build_exp(784);
    send_frame(784, 1);
    drain(196, "resof");
    check("sof_err", {31'b0, frame_err}, 1);

    // reset at beat (15,9)
    fill_rand();
    build_exp(15*28 + 9);
    send_frame(15*28 + 9, 1);
    in_valid = 0;
    check("pre_rst_left", q.size(), 0);
    rst = 1;
    @(negedge clk);
    check("mid_rst_vld", {31'b0, out_valid}, 0);
    check("mid_rst_rdy", {31'b0, in_ready}, 1);
    @(posedge clk);
    #1;
    rst = 0;
    q.delete();
    n_out = 0;
    check("post_rst_err", {31'b0, frame_err}, 0);

    // frame with no SOF after reset
    fill_rand();
    build_exp(784);
    send_frame(784, 0);
    drain(196, "post_rst");

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout got=%0d exp=%0d", n_chk, 0);
    $fatal(1, "timeout");
  end

endmodule
